// File: rtl/bus_uart_tx.sv
// bus_uart_tx: memory-mapped UART transmitter with a 4-entry byte FIFO.
// Registers (relative to BASE_ADDR): +0 TXDATA (write), +1 STATUS, +2 COUNT.
// Optional feature: define UART_TX_PARITY_EN to append an even parity bit
// between the data bits and the stop bit.
module bus_uart_tx #(
    parameter logic [7:0] BASE_ADDR    = 8'hF0,
    parameter int         CLKS_PER_BIT = 16
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic [7:0] i_Addres_Data_Bus,
    input  logic [7:0] i_DataOut_Bus,
    input  logic       i_RW,
    output logic [7:0] o_Dato_Bus,
    output logic       o_Tx,
    output logic       o_Busy
);

    localparam logic [7:0] ADDR_DATA   = BASE_ADDR;
    localparam logic [7:0] ADDR_STATUS = BASE_ADDR + 8'd1;
    localparam logic [7:0] ADDR_COUNT  = BASE_ADDR + 8'd2;
    localparam logic [7:0] BIT_LAST    = 8'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3
`ifdef UART_TX_PARITY_EN
        , S_PARITY = 3'd4
`endif
    } state_t;

`ifdef UART_TX_PARITY_EN
    // Even parity: the transmitted bit makes the total count of ones even.
    function automatic logic even_parity(input logic [7:0] d);
        return ^d;
    endfunction
`endif

    state_t      state_r;
    state_t      state_nx_s;
    logic [7:0]  fifo_mem_r [0:3];
    logic [1:0]  wr_ptr_r;
    logic [1:0]  rd_ptr_r;
    logic [2:0]  count_r;
    logic [2:0]  count_nx_s;
    logic        ovf_r;
    logic        ovf_nx_s;
    logic        wr_prev_r;
    logic [7:0]  shift_r;
    logic [7:0]  shift_nx_s;
    logic [7:0]  clk_cnt_r;
    logic [7:0]  clk_cnt_nx_s;
    logic [2:0]  bit_idx_r;
    logic [2:0]  bit_idx_nx_s;
    logic        tx_r;
    logic        tx_nx_s;
    logic        busy_r;
    logic        pop_s;
`ifdef UART_TX_PARITY_EN
    logic        parity_r;
`endif

    logic match_s;
    logic wr_lvl_s;
    logic wr_fire_s;
    logic push_s;
    logic push_ok_s;
    logic clr_s;
    logic empty_s;
    logic full_s;
    logic tx_active_s;

    // A strobe acts once: only its first cycle (previous level low) fires.
    assign match_s     = (i_Addres_Data_Bus == ADDR_DATA) ||
                         (i_Addres_Data_Bus == ADDR_STATUS) ||
                         (i_Addres_Data_Bus == ADDR_COUNT);
    assign wr_lvl_s    = i_RW & match_s;
    assign wr_fire_s   = wr_lvl_s & ~wr_prev_r;
    assign push_s      = wr_fire_s & (i_Addres_Data_Bus == ADDR_DATA);
    assign clr_s       = wr_fire_s & (i_Addres_Data_Bus == ADDR_STATUS) & i_DataOut_Bus[2];
    assign empty_s     = (count_r == 3'd0);
    assign full_s      = (count_r == 3'd4);
    assign tx_active_s = (state_r != S_IDLE);
    // A full FIFO still accepts a push when the head is popped on the same edge.
    assign push_ok_s   = push_s & (~full_s | pop_s);

    assign o_Tx   = tx_r;
    assign o_Busy = busy_r;

    // Register read mux; TXDATA and unmapped addresses read as zero.
    always_comb begin
        o_Dato_Bus = 8'h00;
        case (i_Addres_Data_Bus)
            ADDR_STATUS: o_Dato_Bus = {4'b0000, tx_active_s, ovf_r, full_s, empty_s};
            ADDR_COUNT:  o_Dato_Bus = {5'b00000, count_r};
            default:     o_Dato_Bus = 8'h00;
        endcase
    end

    // FIFO occupancy and sticky overflow; an overflowing push beats a clear.
    always_comb begin
        count_nx_s = count_r;
        ovf_nx_s   = ovf_r;
        case ({push_ok_s, pop_s})
            2'b10:   count_nx_s = count_r + 3'd1;
            2'b01:   count_nx_s = count_r - 3'd1;
            default: count_nx_s = count_r;
        endcase
        if (clr_s) begin
            ovf_nx_s = 1'b0;
        end else begin
            ovf_nx_s = ovf_r;
        end
        if (push_s && !push_ok_s) begin
            ovf_nx_s = 1'b1;
        end else begin
            ovf_nx_s = ovf_nx_s;
        end
    end

    // Transmit FSM: next state, bit timing, shifting and line level for this state.
    always_comb begin
        state_nx_s   = state_r;
        pop_s        = 1'b0;
        shift_nx_s   = shift_r;
        clk_cnt_nx_s = clk_cnt_r;
        bit_idx_nx_s = bit_idx_r;
        tx_nx_s      = 1'b1;
        case (state_r)
            S_IDLE: begin
                tx_nx_s = 1'b1;
                if (!empty_s) begin
                    state_nx_s   = S_START;
                    pop_s        = 1'b1;
                    shift_nx_s   = fifo_mem_r[rd_ptr_r];
                    clk_cnt_nx_s = BIT_LAST;
                    bit_idx_nx_s = 3'd0;
                end else begin
                    state_nx_s = S_IDLE;
                end
            end
            S_START: begin
                tx_nx_s = 1'b0;
                if (clk_cnt_r == 8'd0) begin
                    state_nx_s   = S_DATA;
                    clk_cnt_nx_s = BIT_LAST;
                    bit_idx_nx_s = 3'd0;
                end else begin
                    clk_cnt_nx_s = clk_cnt_r - 8'd1;
                end
            end
            S_DATA: begin
                tx_nx_s = shift_r[0];
                if (clk_cnt_r == 8'd0) begin
                    clk_cnt_nx_s = BIT_LAST;
                    shift_nx_s   = {1'b0, shift_r[7:1]};
                    if (bit_idx_r == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_nx_s = S_PARITY;
`else
                        state_nx_s = S_STOP;
`endif
                        bit_idx_nx_s = 3'd0;
                    end else begin
                        bit_idx_nx_s = bit_idx_r + 3'd1;
                    end
                end else begin
                    clk_cnt_nx_s = clk_cnt_r - 8'd1;
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                tx_nx_s = parity_r;
                if (clk_cnt_r == 8'd0) begin
                    state_nx_s   = S_STOP;
                    clk_cnt_nx_s = BIT_LAST;
                end else begin
                    clk_cnt_nx_s = clk_cnt_r - 8'd1;
                end
            end
`endif
            S_STOP: begin
                tx_nx_s = 1'b1;
                if (clk_cnt_r == 8'd0) begin
                    state_nx_s = S_IDLE;
                end else begin
                    clk_cnt_nx_s = clk_cnt_r - 8'd1;
                end
            end
            default: begin
                state_nx_s = S_IDLE;
                tx_nx_s    = 1'b1;
            end
        endcase
    end

    // State, FIFO storage and registered line outputs; Rst low clears everything.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state_r   <= S_IDLE;
            wr_ptr_r  <= 2'd0;
            rd_ptr_r  <= 2'd0;
            count_r   <= 3'd0;
            ovf_r     <= 1'b0;
            wr_prev_r <= 1'b0;
            shift_r   <= 8'h00;
            clk_cnt_r <= 8'd0;
            bit_idx_r <= 3'd0;
            tx_r      <= 1'b1;
            busy_r    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_r  <= 1'b0;
`endif
            for (int i = 0; i < 4; i++) begin
                fifo_mem_r[i] <= 8'h00;
            end
        end else begin
            state_r   <= state_nx_s;
            wr_prev_r <= wr_lvl_s;
            count_r   <= count_nx_s;
            ovf_r     <= ovf_nx_s;
            shift_r   <= shift_nx_s;
            clk_cnt_r <= clk_cnt_nx_s;
            bit_idx_r <= bit_idx_nx_s;
            tx_r      <= tx_nx_s;
            busy_r    <= tx_active_s | ~empty_s;
            if (push_ok_s) begin
                fifo_mem_r[wr_ptr_r] <= i_DataOut_Bus;
                wr_ptr_r             <= wr_ptr_r + 2'd1;
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + 2'd1;
`ifdef UART_TX_PARITY_EN
                parity_r <= even_parity(fifo_mem_r[rd_ptr_r]);
`endif
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
        end
    end

endmodule
